// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scan controller: one-hot column strobe, row synchroniser,
// press/release debounce, scan freeze while held, valid/ready key events.
module keypad_scan_ctrl #(
   parameter int COLS         = 4,
   parameter int ROWS         = 4,
   parameter int SETTLE_CYC   = 3,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic                            slow_clk,
   input  logic                            rst,
   input  logic [ROWS-1:0]                 rows_in,
   output logic [COLS-1:0]                 col_out,
   output logic [$clog2(COLS)-1:0]         col_idx,
   output logic                            key_valid,
   output logic [$clog2(ROWS*COLS)-1:0]    key_code,
   input  logic                            key_ready,
   output logic                            key_held,
   output logic                            overrun
);

   localparam int CW = $clog2(COLS);
   localparam int KW = $clog2(ROWS * COLS);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [ROWS-1:0] sync1_q, sync1_d;
   logic [ROWS-1:0] rows_s_q, rows_s_d;
   logic [ROWS-1:0] pat_q, pat_d;
   logic [RW-1:0]   row_q, row_d;
   logic [COLS-1:0] col_out_q, col_out_d;
   logic [CW-1:0]   col_idx_q, col_idx_d;
   logic [SW-1:0]   dwell_q, dwell_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic [KW-1:0]   code_q, code_d;
   logic            held_q, held_d;
   logic            ovr_q, ovr_d;

   logic [RW-1:0]   low_idx;
   logic [RW-1:0]   conf_row;
   logic            advance;
   logic            confirm;

   // Next-state: scan/debounce/hold sequencing and event slot handshake
   always_comb begin
      state_d   = state_q;
      sync1_d   = rows_in;
      rows_s_d  = sync1_q;
      pat_d     = pat_q;
      row_d     = row_q;
      col_out_d = col_out_q;
      col_idx_d = col_idx_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      code_d    = code_q;
      held_d    = held_q;
      ovr_d     = 1'b0;
      advance   = 1'b0;
      confirm   = 1'b0;
      conf_row  = row_q;
      low_idx   = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (rows_s_q[i]) low_idx = RW'(i);
      end
      case (state_q)
         SCAN: begin
            if (dwell_q == SW'(SETTLE_CYC)) begin
               if (rows_s_q == '0) begin
                  advance = 1'b1;
               end else begin
                  pat_d    = rows_s_q;
                  row_d    = low_idx;
                  conf_row = low_idx;
                  dwell_d  = '0;
                  if (DEBOUNCE_CYC == 1) begin
                     confirm = 1'b1;
                  end else begin
                     state_d = DEBOUNCE;
                     cnt_d   = DW'(1);
                  end
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rows_s_q == pat_q) begin
               if (cnt_q == DW'(DEBOUNCE_CYC - 1)) confirm = 1'b1;
               else cnt_d = cnt_q + 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         HOLD: begin
            if (rows_s_q == '0) begin
               if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                  held_d  = 1'b0;
                  advance = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: state_d = SCAN;
      endcase
      if (advance) begin
         state_d   = SCAN;
         dwell_d   = '0;
         cnt_d     = '0;
         col_out_d = {col_out_q[COLS-2:0], col_out_q[COLS-1]};
         col_idx_d = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
      end
      if (confirm) begin
         state_d = HOLD;
         held_d  = 1'b1;
         cnt_d   = '0;
         if (!valid_q || key_ready) begin
            valid_d = 1'b1;
            code_d  = KW'(int'(conf_row) * COLS + int'(col_idx_q));
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && key_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge slow_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= SCAN;
         sync1_q   <= '0;
         rows_s_q  <= '0;
         pat_q     <= '0;
         row_q     <= '0;
         col_out_q <= COLS'(1);
         col_idx_q <= '0;
         dwell_q   <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         code_q    <= '0;
         held_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         rows_s_q  <= rows_s_d;
         pat_q     <= pat_d;
         row_q     <= row_d;
         col_out_q <= col_out_d;
         col_idx_q <= col_idx_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         code_q    <= code_d;
         held_q    <= held_d;
         ovr_q     <= ovr_d;
      end
   end

   assign col_out   = col_out_q;
   assign col_idx   = col_idx_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_held  = held_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a simple key-matrix model
// and per-cycle output traces sampled on the falling edge.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rows_in;
   logic [3:0] col_out;
   logic [1:0] col_idx;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       key_held;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   logic       pen;
   int         pcol;
   logic [3:0] prow;

   int         tn;
   logic       tr_v  [80];
   logic       tr_h  [80];
   logic       tr_o  [80];
   logic [3:0] tr_code [80];
   logic [1:0] tr_col  [80];
   logic [3:0] tr_cout [80];

   keypad_scan_ctrl dut (
      .slow_clk  (clk),
      .rst       (rst_n),
      .rows_in   (rows_in),
      .col_out   (col_out),
      .col_idx   (col_idx),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      rows_in = (pen && col_out[pcol]) ? prow : 4'b0000;
      if (tn < 80) begin
         tr_v[tn]    = key_valid;
         tr_h[tn]    = key_held;
         tr_o[tn]    = overrun;
         tr_code[tn] = key_code;
         tr_col[tn]  = col_idx;
         tr_cout[tn] = col_out;
      end
      tn++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      pen       = 1'b0;
      pcol      = 0;
      prow      = 4'b0000;
      key_ready = 1'b0;
      rows_in   = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tn    = 0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      rows_in = 4'b1111;
      repeat (3) @(negedge clk);
      checks++;
      if ({col_out, col_idx, key_valid, key_code, key_held, overrun}
          !== {4'b0001, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_vals got col=%b idx=%0d v=%b code=%0d h=%b o=%b",
                  col_out, col_idx, key_valid, key_code, key_held, overrun);
      end
   endtask

   task automatic test_idle_scan();
      int nv;
      do_reset();
      for (int i = 0; i < 40; i++) step();
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (tr_cout[i] !== 4'(1 << ((i / 4) % 4))) begin
            errors++;
            $display("FAIL idle_col i=%0d got %b want %b",
                     i, tr_cout[i], 4'(1 << ((i / 4) % 4)));
         end
         checks++;
         if (tr_col[i] !== 2'((i / 4) % 4)) begin
            errors++;
            $display("FAIL idle_idx i=%0d got %0d want %0d",
                     i, tr_col[i], (i / 4) % 4);
         end
         if (tr_v[i]) nv++;
      end
      checks++;
      if (nv !== 0) begin
         errors++;
         $display("FAIL idle_valid got %0d valid cycles want 0", nv);
      end
   endtask

   task automatic test_clean_press();
      int nv, nh, no, bad;
      do_reset();
      key_ready = 1'b1;
      pcol = 1;
      prow = 4'b0100;
      for (int i = 0; i < 40; i++) begin
         pen = (i < 24);
         step();
      end
      nv = 0; nh = 0; no = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (tr_v[i]) nv++;
         if (tr_h[i]) nh++;
         if (tr_o[i]) no++;
         if ($countones(tr_cout[i]) != 1) bad++;
      end
      checks++;
      if ({tr_v[10], tr_v[11], tr_v[12]} !== 3'b010) begin
         errors++;
         $display("FAIL press_valid_timing got %b%b%b want 010",
                  tr_v[10], tr_v[11], tr_v[12]);
      end
      checks++;
      if (tr_code[11] !== 4'd9) begin
         errors++;
         $display("FAIL press_code got %0d want 9", tr_code[11]);
      end
      checks++;
      if (nv !== 1) begin
         errors++;
         $display("FAIL press_valid_count got %0d want 1", nv);
      end
      checks++;
      if ({tr_h[10], tr_h[11], tr_h[29], tr_h[30]} !== 4'b0110) begin
         errors++;
         $display("FAIL press_held_edges got %b%b%b%b want 0110",
                  tr_h[10], tr_h[11], tr_h[29], tr_h[30]);
      end
      checks++;
      if (nh !== 19) begin
         errors++;
         $display("FAIL press_held_len got %0d want 19", nh);
      end
      checks++;
      if ({tr_col[29], tr_col[30]} !== {2'd1, 2'd2}) begin
         errors++;
         $display("FAIL press_resume got %0d,%0d want 1,2",
                  tr_col[29], tr_col[30]);
      end
      checks++;
      if (no !== 0 || bad !== 0) begin
         errors++;
         $display("FAIL press_ovr_onehot got ovr=%0d bad=%0d want 0,0", no, bad);
      end
   endtask

   task automatic test_bounce();
      int nv, nh;
      do_reset();
      key_ready = 1'b1;
      pcol = 3;
      prow = 4'b0001;
      for (int i = 0; i < 30; i++) begin
         pen = (i == 12 || i == 13);
         step();
      end
      nv = 0; nh = 0;
      for (int i = 0; i < 30; i++) begin
         if (tr_v[i]) nv++;
         if (tr_h[i]) nh++;
      end
      checks++;
      if (nv !== 0 || nh !== 0) begin
         errors++;
         $display("FAIL bounce_event got v=%0d h=%0d want 0,0", nv, nh);
      end
      checks++;
      if ({tr_col[16], tr_col[17], tr_col[21]} !== {2'd3, 2'd0, 2'd1}) begin
         errors++;
         $display("FAIL bounce_cols got %0d,%0d,%0d want 3,0,1",
                  tr_col[16], tr_col[17], tr_col[21]);
      end
   endtask

   task automatic test_multirow();
      int nv;
      do_reset();
      key_ready = 1'b1;
      pcol = 3;
      prow = 4'b1010;
      pen  = 1'b1;
      for (int i = 0; i < 30; i++) step();
      nv = 0;
      for (int i = 0; i < 30; i++) if (tr_v[i]) nv++;
      checks++;
      if ({tr_v[18], tr_v[19]} !== 2'b01 || tr_code[19] !== 4'd7) begin
         errors++;
         $display("FAIL multirow_code got v=%b%b code=%0d want 01 code 7",
                  tr_v[18], tr_v[19], tr_code[19]);
      end
      checks++;
      if (nv !== 1) begin
         errors++;
         $display("FAIL multirow_count got %0d want 1", nv);
      end
   endtask

   task automatic test_overrun();
      int nv, no, badc;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         if (i < 24) begin
            pen = 1'b1; pcol = 1; prow = 4'b0100;
         end else if (i >= 31 && i < 50) begin
            pen = 1'b1; pcol = 3; prow = 4'b0010;
         end else begin
            pen = 1'b0;
         end
         key_ready = (i == 60);
         step();
      end
      key_ready = 1'b0;
      nv = 0; no = 0; badc = 0;
      for (int i = 0; i < 64; i++) begin
         if (tr_v[i]) nv++;
         if (tr_o[i]) no++;
         if (tr_v[i] && tr_code[i] !== 4'd9) badc++;
      end
      checks++;
      if (no !== 1 || tr_o[41] !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pulse got count=%0d at41=%b want 1,1", no, tr_o[41]);
      end
      checks++;
      if (nv !== 50) begin
         errors++;
         $display("FAIL ovr_valid_len got %0d want 50", nv);
      end
      checks++;
      if (badc !== 0) begin
         errors++;
         $display("FAIL ovr_code_kept got %0d bad cycles want 0", badc);
      end
      checks++;
      if ({tr_v[60], tr_v[61]} !== 2'b10) begin
         errors++;
         $display("FAIL ovr_accept got %b%b want 10", tr_v[60], tr_v[61]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pcol = 1;
      prow = 4'b0100;
      pen  = 1'b1;
      for (int i = 0; i < 16; i++) step();
      checks++;
      if ({key_held, key_valid} !== 2'b11) begin
         errors++;
         $display("FAIL areset_pre got h=%b v=%b want 1,1", key_held, key_valid);
      end
      #2;
      rst_n   = 1'b0;
      pen     = 1'b0;
      rows_in = 4'b0000;
      #1;
      checks++;
      if ({col_out, col_idx, key_valid, key_code, key_held, overrun}
          !== {4'b0001, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL areset_vals got col=%b idx=%0d v=%b code=%0d h=%b o=%b",
                  col_out, col_idx, key_valid, key_code, key_held, overrun);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tn    = 0;
      for (int i = 0; i < 8; i++) step();
      checks++;
      if ({tr_col[0], tr_col[3], tr_col[4]} !== {2'd0, 2'd0, 2'd1}
          || tr_v[7] !== 1'b0) begin
         errors++;
         $display("FAIL areset_restart got %0d,%0d,%0d v=%b want 0,0,1 v=0",
                  tr_col[0], tr_col[3], tr_col[4], tr_v[7]);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rows_in   = 4'b0000;
      key_ready = 1'b0;
      pen       = 1'b0;
      pcol      = 0;
      prow      = 4'b0000;
      tn        = 0;
      @(negedge clk);
      test_reset();
      test_idle_scan();
      test_clean_press();
      test_bounce();
      test_multirow();
      test_overrun();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
